// File: rtl/lcd_timing_pkg.sv
// Shared timing definitions for the LCD scan controller.
// Holds the scan state encoding, default panel timing and the line/frame total helpers.
package lcd_timing_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRun      = 2'd1,
        StStopping = 2'd2
    } scan_state_e;

    localparam int unsigned DefHActive = 320;
    localparam int unsigned DefHFp     = 8;
    localparam int unsigned DefHSync   = 4;
    localparam int unsigned DefHBp     = 8;
    localparam int unsigned DefVActive = 240;
    localparam int unsigned DefVFp     = 4;
    localparam int unsigned DefVSync   = 2;
    localparam int unsigned DefVBp     = 4;
    localparam int unsigned DefHw      = 10;
    localparam int unsigned DefVw      = 9;

    function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Width-parameterised up-counter with enable, synchronous clear and wrap at Last.
// Exposes the next-state value so callers can decode registered outputs in step.
module scan_counter #(
    parameter int unsigned Width = 10,
    parameter int unsigned Last  = 7
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o,
    output logic [Width-1:0] nxt_o,
    output logic             tc_o
);

    localparam logic [Width-1:0] LastVal = Width'(Last);

    logic [Width-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == LastVal);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign nxt_o = cnt_d;

endmodule

// File: rtl/lcd_scan_ctrl.sv
// LCD frame-timing scheduler: x/y scan counters, data-enable, syncs and frame strobes.
// Optional LCD_SCAN_FRAME_COUNT_EN adds an 8-bit wrapping frame counter output.
module lcd_scan_ctrl
    import lcd_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp,
    parameter int unsigned HW       = DefHw,
    parameter int unsigned VW       = DefVw
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          pix_en,
    input  logic          start,
    input  logic          stop,
    output logic          busy,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start,
    output logic          frame_done
`ifdef LCD_SCAN_FRAME_COUNT_EN
    ,
    output logic [7:0]    frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // One extra bit so a boundary equal to 2^HW / 2^VW still compares correctly.
    localparam logic [HW:0] HActEnd = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0] HsBeg   = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0] HsEnd   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0] VActEnd = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0] VsBeg   = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0] VsEnd   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

    scan_state_e state_q, state_d;

    logic          scanning, step, wrap, clr;
    logic          x_tc, y_tc;
    logic [HW-1:0] x_nxt;
    logic [VW-1:0] y_nxt;
    logic [HW:0]   x_ext;
    logic [VW:0]   y_ext;

    logic busy_q, busy_d;
    logic de_q, de_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic fs_q, fs_d;
    logic fd_q, fd_d;

    assign scanning = (state_q != StIdle);
    assign step     = scanning & pix_en;
    assign wrap     = step & x_tc & y_tc;
    assign clr      = (state_d == StIdle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start) state_d = StRun;
            StRun:      if (stop)  state_d = StStopping;
            StStopping: if (wrap)  state_d = StIdle;
            default:               state_d = StIdle;
        endcase
    end

    scan_counter #(
        .Width (HW),
        .Last  (H_TOTAL - 1)
    ) u_x_cnt (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .clr_i  (clr),
        .en_i   (step),
        .cnt_o  (x),
        .nxt_o  (x_nxt),
        .tc_o   (x_tc)
    );

    scan_counter #(
        .Width (VW),
        .Last  (V_TOTAL - 1)
    ) u_y_cnt (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .clr_i  (clr),
        .en_i   (step & x_tc),
        .cnt_o  (y),
        .nxt_o  (y_nxt),
        .tc_o   (y_tc)
    );

    assign x_ext = {1'b0, x_nxt};
    assign y_ext = {1'b0, y_nxt};

    // Strobes decode the next-state counters so they line up with the registered x/y.
    always_comb begin
        busy_d  = (state_d != StIdle);
        de_d    = busy_d && (x_ext < HActEnd) && (y_ext < VActEnd);
        hsync_d = busy_d && (x_ext >= HsBeg) && (x_ext < HsEnd);
        vsync_d = busy_d && (y_ext >= VsBeg) && (y_ext < VsEnd);
        fs_d    = ((state_q == StIdle) && start) || ((state_q == StRun) && wrap);
        fd_d    = wrap;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            de_q    <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
            fd_q    <= fd_d;
        end
    end

    assign busy        = busy_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;
    assign frame_done  = fd_q;

`ifdef LCD_SCAN_FRAME_COUNT_EN
    logic [7:0] fcnt_q, fcnt_d;

    always_comb begin
        fcnt_d = fcnt_q;
        if ((state_q == StIdle) && (state_d != StIdle)) begin
            fcnt_d = '0;
        end else if (wrap) begin
            fcnt_d = fcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_lcd_scan_ctrl.sv
// Directed bench for lcd_scan_ctrl with a tiny 8x6 timing: vector table plus frame sequences.
module tb_lcd_scan_ctrl;

    localparam int HT = 8;
    localparam int VT = 6;
    localparam int FT = HT * VT;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       pix_en = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       busy, de, hsync, vsync, frame_start, frame_done;
    logic [3:0] x;
    logic [2:0] y;
`ifdef LCD_SCAN_FRAME_COUNT_EN
    logic [7:0] frame_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Expected-behaviour model: frame position and run/stop state.
    int pos = 0;
    bit m_busy = 1'b0;
    bit m_stop = 1'b0;
    int m_fcnt = 0;

    typedef struct {
        logic st, sp, pe;
        int   ex, ey;
        logic de, hs, vs, bz, fs, fd;
    } vec_t;

    always #5 clock = ~clock;

    lcd_scan_ctrl #(
        .H_ACTIVE (4),
        .H_FP     (1),
        .H_SYNC   (2),
        .H_BP     (1),
        .V_ACTIVE (3),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .HW       (4),
        .VW       (3)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pix_en      (pix_en),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .x           (x),
        .y           (y),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .frame_done  (frame_done)
`ifdef LCD_SCAN_FRAME_COUNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_x"}, int'(x), 0);
        chk({tag, "_y"}, int'(y), 0);
        chk({tag, "_de"}, int'(de), 0);
        chk({tag, "_hsync"}, int'(hsync), 0);
        chk({tag, "_vsync"}, int'(vsync), 0);
        chk({tag, "_fs"}, int'(frame_start), 0);
        chk({tag, "_fd"}, int'(frame_done), 0);
`ifdef LCD_SCAN_FRAME_COUNT_EN
        chk({tag, "_fcnt"}, int'(frame_cnt), 0);
`endif
    endtask

    task automatic check_outputs(input int efs, input int efd);
        int ex, ey;
        ex = pos % HT;
        ey = pos / HT;
        chk("x", int'(x), ex);
        chk("y", int'(y), ey);
        chk("busy", int'(busy), m_busy ? 1 : 0);
        chk("de", int'(de), (m_busy && ex < 4 && ey < 3) ? 1 : 0);
        chk("hsync", int'(hsync), (m_busy && (ex == 5 || ex == 6)) ? 1 : 0);
        chk("vsync", int'(vsync), (m_busy && ey == 4) ? 1 : 0);
        chk("frame_start", int'(frame_start), efs);
        chk("frame_done", int'(frame_done), efd);
`ifdef LCD_SCAN_FRAME_COUNT_EN
        chk("frame_cnt", int'(frame_cnt), m_fcnt);
`endif
    endtask

    task automatic tick(input logic st, input logic sp, input logic pe);
        int efs, efd;
        bit was_run;
        efs = 0;
        efd = 0;
        start = st;
        stop = sp;
        pix_en = pe;
        was_run = m_busy && !m_stop;
        if (!m_busy) begin
            if (st) begin
                m_busy = 1'b1;
                efs = 1;
                pos = 0;
                m_fcnt = 0;
            end
        end else if (pe) begin
            if (pos == FT - 1) begin
                pos = 0;
                efd = 1;
                m_fcnt = (m_fcnt + 1) % 256;
                if (m_stop) begin
                    m_busy = 1'b0;
                    m_stop = 1'b0;
                end else begin
                    efs = 1;
                end
            end else begin
                pos++;
            end
        end
        if (was_run && sp) m_stop = 1'b1;
        @(posedge clock);
        #1;
        check_outputs(efs, efd);
    endtask

    initial begin
        vec_t tbl[12];
        int   fd_at[$];
        int   fs_mid, fs_end, guard;

        // Row 0 also raises stop alongside start; it must be ignored.
        tbl[0]  = '{st:1, sp:1, pe:1, ex:0, ey:0, de:1, hs:0, vs:0, bz:1, fs:1, fd:0};
        tbl[1]  = '{st:0, sp:0, pe:1, ex:1, ey:0, de:1, hs:0, vs:0, bz:1, fs:0, fd:0};
        tbl[2]  = '{st:0, sp:0, pe:1, ex:2, ey:0, de:1, hs:0, vs:0, bz:1, fs:0, fd:0};
        tbl[3]  = '{st:0, sp:0, pe:1, ex:3, ey:0, de:1, hs:0, vs:0, bz:1, fs:0, fd:0};
        tbl[4]  = '{st:0, sp:0, pe:1, ex:4, ey:0, de:0, hs:0, vs:0, bz:1, fs:0, fd:0};
        tbl[5]  = '{st:0, sp:0, pe:1, ex:5, ey:0, de:0, hs:1, vs:0, bz:1, fs:0, fd:0};
        tbl[6]  = '{st:0, sp:0, pe:1, ex:6, ey:0, de:0, hs:1, vs:0, bz:1, fs:0, fd:0};
        tbl[7]  = '{st:0, sp:0, pe:1, ex:7, ey:0, de:0, hs:0, vs:0, bz:1, fs:0, fd:0};
        tbl[8]  = '{st:0, sp:0, pe:1, ex:0, ey:1, de:1, hs:0, vs:0, bz:1, fs:0, fd:0};
        tbl[9]  = '{st:0, sp:0, pe:0, ex:0, ey:1, de:1, hs:0, vs:0, bz:1, fs:0, fd:0};
        tbl[10] = '{st:1, sp:0, pe:0, ex:0, ey:1, de:1, hs:0, vs:0, bz:1, fs:0, fd:0};
        tbl[11] = '{st:0, sp:0, pe:1, ex:1, ey:1, de:1, hs:0, vs:0, bz:1, fs:0, fd:0};

        #12;
        zero_check("in_reset");
        reset_n = 1'b1;
        pix_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            zero_check("idle");
        end

        for (int i = 0; i < 12; i++) begin
            start = tbl[i].st;
            stop = tbl[i].sp;
            pix_en = tbl[i].pe;
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_x", i), int'(x), tbl[i].ex);
            chk($sformatf("v%0d_y", i), int'(y), tbl[i].ey);
            chk($sformatf("v%0d_de", i), int'(de), int'(tbl[i].de));
            chk($sformatf("v%0d_hsync", i), int'(hsync), int'(tbl[i].hs));
            chk($sformatf("v%0d_vsync", i), int'(vsync), int'(tbl[i].vs));
            chk($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].bz));
            chk($sformatf("v%0d_fs", i), int'(frame_start), int'(tbl[i].fs));
            chk($sformatf("v%0d_fd", i), int'(frame_done), int'(tbl[i].fd));
        end
        pos = 9;
        m_busy = 1'b1;
        m_stop = 1'b0;
        m_fcnt = 0;

        // Free run across two frame boundaries.
        for (int i = 1; i <= 90; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (frame_done) fd_at.push_back(i);
        end
        chk("free_run_fd_count", fd_at.size(), 2);
        if (fd_at.size() == 2) chk("free_run_fd_spacing", fd_at[1] - fd_at[0], FT);

        // Stop requested on line 1; scan must finish the frame and drop to idle.
        guard = 0;
        while (pos != 8 && guard < 60) begin
            tick(1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("reach_line1_x", int'(x), 0);
        chk("reach_line1_y", int'(y), 1);
        tick(1'b0, 1'b1, 1'b1);
        guard = 0;
        while (m_busy && guard < 60) begin
            tick(1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("stop_busy_low", int'(busy), 0);
        chk("stop_fd_pulse", int'(frame_done), 1);
        chk("stop_no_fs", int'(frame_start), 0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1);

        // pix_en one cycle in three: frame spans 144 clocks.
        tick(1'b1, 1'b0, 1'b0);
        chk("slow_fs_first", int'(frame_start), 1);
        fs_mid = 0;
        fs_end = 0;
        for (int c = 1; c <= 3 * FT; c++) begin
            tick(1'b0, 1'b0, (c % 3) == 0);
            if (frame_start && c < 3 * FT) fs_mid++;
            if (c == 3 * FT) fs_end = int'(frame_start);
        end
        chk("slow_fs_midframe", fs_mid, 0);
        chk("slow_fs_at_144", fs_end, 1);

        // Asynchronous reset mid-frame at (3,2).
        guard = 0;
        while (pos != 19 && guard < 60) begin
            tick(1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("at_3_2_x", int'(x), 3);
        chk("at_3_2_y", int'(y), 2);
        #2;
        reset_n = 1'b0;
        #1;
        zero_check("async_rst");
        pos = 0;
        m_busy = 1'b0;
        m_stop = 1'b0;
        m_fcnt = 0;
        @(posedge clock);
        #1;
        zero_check("rst_held");
        reset_n = 1'b1;

        tick(1'b1, 1'b0, 1'b1);
        chk("restart_fs", int'(frame_start), 1);
        for (int i = 0; i < FT; i++) tick(1'b0, 1'b0, 1'b1);
        chk("restart_fd", int'(frame_done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
